// File: rtl/mpu_macros_pkg.sv
// rtl/mpu_macros_pkg.sv - shared MPU encodings, MAC addresses, sizes and frame constants
package mpu_macros_pkg;

    localparam int ACC_SIZE    = 24;
    localparam int MATRIX_SIZE = 10;

    localparam logic [47:0] MAC_HOST = 48'hDC0EA1F0573B;
    localparam logic [47:0] MAC_MPU  = 48'h5044332211EE;

    localparam logic [1:0] STREAM_NONE    = 2'd0;
    localparam logic [1:0] STREAM_DATA    = 2'd1;
    localparam logic [1:0] STREAM_ERR_DIM = 2'd2;
    localparam logic [1:0] STREAM_ERR_CMD = 2'd3;

    localparam logic [2:0] FRAME_NONE    = 3'b000;
    localparam logic [2:0] FRAME_DATA    = 3'b001;
    localparam logic [2:0] FRAME_ERR_CMD = 3'b010;
    localparam logic [2:0] FRAME_ERR_DIM = 3'b011;

    localparam int FRAME_HDR_LEN = 15;
    localparam int FRAME_MIN_LEN = 60;

    function automatic logic [2:0] stream_to_frame(input logic [1:0] stream_type);
        case (stream_type)
            STREAM_DATA:    return FRAME_DATA;
            STREAM_ERR_DIM: return FRAME_ERR_DIM;
            STREAM_ERR_CMD: return FRAME_ERR_CMD;
            default:        return FRAME_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mpu_tx_serializer.sv
// rtl/mpu_tx_serializer.sv - result element to byte shift register, MSB byte first
module mpu_tx_serializer #(
    parameter int ACC_SIZE = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fetch_en,
    input  logic                pop,
    input  logic                elem_valid,
    output logic                elem_ready,
    input  logic [ACC_SIZE-1:0] elem_data,
    output logic [7:0]          byte_data,
    output logic                byte_valid
);

    localparam int EL_BYTES = ACC_SIZE / 8;
    localparam int CW       = $clog2(EL_BYTES + 1);

    logic [ACC_SIZE-1:0] sr;
    logic [CW-1:0]       cnt;
    logic                empty;

    assign empty      = (cnt == '0);
    assign elem_ready = fetch_en && (empty || ((cnt == CW'(1)) && pop));
    // When empty, the incoming element's MSB bypasses the register so the stream has no gap.
    assign byte_valid = !empty || (fetch_en && elem_valid);
    assign byte_data  = empty ? elem_data[ACC_SIZE-1 -: 8] : sr[ACC_SIZE-1 -: 8];

    always_ff @(posedge clk) begin
        if (rst) begin
            sr  <= '0;
            cnt <= '0;
        end else if (elem_valid && elem_ready) begin
            if (empty && pop) begin
                sr  <= elem_data << 8;
                cnt <= CW'(EL_BYTES - 1);
            end else begin
                sr  <= elem_data;
                cnt <= CW'(EL_BYTES);
            end
        end else if (pop && !empty) begin
            sr  <= sr << 8;
            cnt <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/mpu_frame_tx.sv
// rtl/mpu_frame_tx.sv - MPU-to-host result frame transmitter; MPU_FRAME_PAD_EN pads frames to 60 bytes
module mpu_frame_tx #(
    parameter int          ACC_SIZE    = mpu_macros_pkg::ACC_SIZE,
    parameter int          MATRIX_SIZE = mpu_macros_pkg::MATRIX_SIZE,
    parameter logic [47:0] MAC_DST     = mpu_macros_pkg::MAC_HOST,
    parameter logic [47:0] MAC_SRC     = mpu_macros_pkg::MAC_MPU
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                hdr_valid,
    output logic                hdr_ready,
    input  logic [1:0]          hdr_type,
    input  logic [7:0]          hdr_rows,
    input  logic [7:0]          hdr_cols,
    input  logic                elem_valid,
    output logic                elem_ready,
    input  logic [ACC_SIZE-1:0] elem_data,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic                tx_last,
    output logic                busy
);
    import mpu_macros_pkg::*;

    localparam int EL_BYTES = ACC_SIZE / 8;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_HEADER  = 2'd1;
    localparam logic [1:0] S_PAYLOAD = 2'd2;
`ifdef MPU_FRAME_PAD_EN
    localparam logic [1:0] S_PAD     = 2'd3;
`endif

    logic [1:0]   state;
    logic [15:0]  byte_cnt, data_len, frame_len;
    logic [2:0]   ftype;
    logic [7:0]   rows_q, cols_q, elem_cnt, elem_last;
    logic         elems_done, armed;

    logic         load, last_byte, hdr_accept, dims_ok, new_data;
    logic [2:0]   new_type;
    logic [15:0]  n_elems, new_len;
    logic [119:0] hdr_vec, hdr_shift;
    logic [7:0]   src_byte, ser_byte;
    logic         src_valid, ser_valid;

    assign load       = !tx_valid || tx_ready;
    assign last_byte  = (byte_cnt == frame_len - 16'd1);
    // armed keeps hdr_ready low in the cycles where reset is held.
    assign hdr_ready  = armed && (state == S_IDLE) && !tx_valid;
    assign hdr_accept = hdr_valid && hdr_ready;
    assign busy       = (state != S_IDLE) || tx_valid;

    assign dims_ok  = (hdr_rows != 8'd0) && (hdr_rows <= 8'(MATRIX_SIZE)) &&
                      (hdr_cols != 8'd0) && (hdr_cols <= 8'(MATRIX_SIZE));
    assign new_type = (stream_to_frame(hdr_type) == FRAME_DATA && !dims_ok) ? FRAME_ERR_DIM
                                                                           : stream_to_frame(hdr_type);
    assign new_data = (new_type == FRAME_DATA);
    assign n_elems  = 16'(hdr_rows) * 16'(hdr_cols);
    assign new_len  = 16'(FRAME_HDR_LEN) + (new_data ? n_elems * 16'(EL_BYTES) : 16'd0);

    assign hdr_vec   = {MAC_DST, MAC_SRC, 5'b00000, ftype, rows_q, cols_q};
    assign hdr_shift = hdr_vec << {byte_cnt[3:0], 3'b000};

    always_comb begin
        src_valid = 1'b0;
        src_byte  = 8'h00;
        case (state)
            S_HEADER: begin
                src_valid = 1'b1;
                src_byte  = hdr_shift[119:112];
            end
            S_PAYLOAD: begin
                src_valid = ser_valid;
                src_byte  = ser_byte;
            end
`ifdef MPU_FRAME_PAD_EN
            S_PAD: src_valid = 1'b1;
`endif
            default: ;
        endcase
    end

    mpu_tx_serializer #(.ACC_SIZE(ACC_SIZE)) u_ser (
        .clk        (clk),
        .rst        (rst),
        .fetch_en   ((state == S_PAYLOAD) && !elems_done),
        .pop        ((state == S_PAYLOAD) && load),
        .elem_valid (elem_valid),
        .elem_ready (elem_ready),
        .elem_data  (elem_data),
        .byte_data  (ser_byte),
        .byte_valid (ser_valid)
    );

`ifndef MPU_FRAME_PAD_EN
    assign frame_len = data_len;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            byte_cnt   <= '0;
            data_len   <= '0;
            ftype      <= '0;
            rows_q     <= '0;
            cols_q     <= '0;
            elem_cnt   <= '0;
            elem_last  <= '0;
            elems_done <= 1'b0;
            armed      <= 1'b0;
            tx_valid   <= 1'b0;
            tx_data    <= '0;
            tx_last    <= 1'b0;
`ifdef MPU_FRAME_PAD_EN
            frame_len  <= '0;
`endif
        end else begin
            armed <= 1'b1;
            if (elem_valid && elem_ready) begin
                if (elem_cnt == elem_last) elems_done <= 1'b1;
                else                       elem_cnt   <= elem_cnt + 8'd1;
            end
            if (load) begin
                if (src_valid) begin
                    tx_data  <= src_byte;
                    tx_valid <= 1'b1;
                    tx_last  <= last_byte;
                    byte_cnt <= byte_cnt + 16'd1;
                end else begin
                    tx_valid <= 1'b0;
                    tx_last  <= 1'b0;
                end
            end
            if (load && src_valid) begin
                if (last_byte) begin
                    state <= S_IDLE;
                end else if (state == S_HEADER && byte_cnt == 16'(FRAME_HDR_LEN - 1)) begin
`ifdef MPU_FRAME_PAD_EN
                    state <= (ftype == FRAME_DATA) ? S_PAYLOAD : S_PAD;
                end else if (state == S_PAYLOAD && byte_cnt == data_len - 16'd1) begin
                    state <= S_PAD;
`else
                    state <= S_PAYLOAD;
`endif
                end
            end
            if (hdr_accept && hdr_type != STREAM_NONE) begin
                ftype      <= new_type;
                rows_q     <= new_data ? hdr_rows : 8'd0;
                cols_q     <= new_data ? hdr_cols : 8'd0;
                data_len   <= new_len;
`ifdef MPU_FRAME_PAD_EN
                frame_len  <= (new_len < 16'(FRAME_MIN_LEN)) ? 16'(FRAME_MIN_LEN) : new_len;
`endif
                elem_last  <= 8'(n_elems - 16'd1);
                elem_cnt   <= '0;
                elems_done <= 1'b0;
                byte_cnt   <= '0;
                state      <= S_HEADER;
            end
        end
    end

endmodule

// File: doc/mpu_frame_tx.md
Name: mpu_frame_tx

Overview:
- Host-bound response transmitter for the MPU.
- Takes a result descriptor (stream type plus dimensions) and the ACC_SIZE result elements that follow it.
- Serialises them into an Ethernet-style byte frame addressed to the host: MAC header, frame-type byte, dims, big-endian payload.
- It is the transmit-side counterpart of the host-to-MPU command frame receiver and feeds the MAC TX byte interface.

Parameters:
- ACC_SIZE, 24, result element width in bits; must be a multiple of 8 (EL_BYTES = ACC_SIZE/8).
- MATRIX_SIZE, 10, maximum rows and maximum cols.
- MAC_DST, 48'hDC0EA1F0573B, destination MAC (host).
- MAC_SRC, 48'h5044332211EE, source MAC (MPU).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- hdr_valid  in  1  descriptor valid
- hdr_ready  out  1  descriptor accepted when valid&&ready
- hdr_type  in  2  STREAM_NONE/DATA/ERR_DIM/ERR_CMD
- hdr_rows  in  8  result rows
- hdr_cols  in  8  result cols
- elem_valid  in  1  element valid
- elem_ready  out  1  element accepted when valid&&ready
- elem_data  in  ACC_SIZE  result element, row-major order
- tx_data  out  8  frame byte
- tx_valid  out  1  byte valid
- tx_ready  in  1  sink accepts byte
- tx_last  out  1  final byte of frame
- busy  out  1  high from descriptor accept until last byte accepted

Behaviour:
- Reset values: hdr_ready=0, elem_ready=0, tx_valid=0, tx_data=0, tx_last=0, busy=0. State=IDLE, all counters 0.
- Reset mid-frame abandons the frame immediately. No tx_last is issued and no elements are consumed after reset.
- FSM states: IDLE, HEADER, PAYLOAD, PAD (PAD exists only with the optional feature).
- IDLE
  - hdr_ready=1.
  - On hdr_valid: latch type and dims, set busy, go to HEADER next cycle.
- Type mapping:
  - DATA -> FRAME_DATA (3'b001).
  - ERR_DIM -> FRAME_ERR_DIM (3'b011).
  - ERR_CMD -> FRAME_ERR_CMD (3'b010).
  - NONE: descriptor is consumed and no frame is sent; stay in IDLE; busy stays 0.
- Dim check: a DATA descriptor with rows or cols equal to 0 or greater than MATRIX_SIZE is sent as FRAME_ERR_DIM. No elements are consumed in that case.
- Header layout (15 bytes), MSB first:
  - Bytes 0-5: MAC_DST.
  - Bytes 6-11: MAC_SRC.
  - Byte 12: {5'b0, frame_type}.
  - Byte 13: rows.
  - Byte 14: cols.
  - Error frames carry rows=cols=0 in bytes 13-14.
- Payload:
  - DATA frames only: rows*cols elements, EL_BYTES bytes each, MSB first.
  - Element counter is 8 bits wide, terminal count rows*cols-1.
- Frame lengths:
  - DATA frame: 15 + rows*cols*EL_BYTES bytes.
  - Error frame: exactly 15 bytes.
- tx handshake:
  - A byte transfers on tx_valid&&tx_ready.
  - While tx_valid=1 and tx_ready=0, tx_data and tx_last are held stable.
  - tx_valid never drops before the byte transfers.
- Element fetch:
  - elem_ready=1 only in PAYLOAD when the element shift register is empty, i.e. the last byte of the previous element is transferring this cycle or was already transferred.
  - The accepted element loads the shift register; its MSB byte is presented next.
- Throughput: with tx_ready held high and elem_valid high, one byte per cycle with no bubbles.
- If elem_valid is low mid-payload, tx_valid deasserts until an element arrives. This is legal and does not abort the frame.
- tx_last: asserted with the final byte. After that byte transfers, return to IDLE and clear busy.
- hdr_ready stays 0 while busy. Back-to-back frames: the next descriptor can be accepted the cycle after last-byte transfer.

Optional Feature:
- Macro: MPU_FRAME_PAD_EN.
- Defined:
  - Frames shorter than 60 bytes are extended in PAD state with 8'h00 bytes to exactly 60 bytes.
  - tx_last moves to byte 59.
  - Error frames are always 60 bytes.
- Undefined: no padding; the PAD state and pad counter are absent.

Decomposition:
- Shared package mpu_macros_pkg holds:
  - STREAM_* and FRAME_* encodings.
  - MAC_MPU and MAC_HOST.
  - ACC_SIZE and MATRIX_SIZE.
  - New constant FRAME_HDR_LEN=15.
  - New constant FRAME_MIN_LEN=60.
  - New function stream_to_frame(stream_type) returning a 3-bit frame type.
- One natural sub-module: mpu_tx_serializer, an ACC_SIZE-to-byte shift register with the valid/ready hold logic. The FSM, counters and header mux stay in the top level.

Test Plan:
- DATA, rows=2, cols=2, elements 0x000001, 0x0000FF, 0x123456, 0xFFFFFF, tx_ready=1 -> 27 bytes.
  - Bytes 0-5 DC 0E A1 F0 57 3B; bytes 6-11 50 44 33 22 11 EE; byte12=01; bytes 13-14 = 02 02.
  - Payload 00 00 01 00 00 FF 12 34 56 FF FF FF; tx_last on byte 26; no bubbles.
- ERR_CMD descriptor -> 15 bytes, byte12=02, bytes 13-14 = 00 00, tx_last on byte 14, elem_ready never asserted.
- DATA with rows=11, cols=3 -> 15-byte frame with byte12=03 and dims 00 00; elem_ready stays 0. Repeat with cols=0 -> same result.
- DATA 1x1 with tx_ready toggling randomly and elem_valid delayed 5 cycles -> tx_data stable while stalled; byte sequence identical to the no-stall case.
- STREAM_NONE descriptor -> hdr_ready pulse consumed, no tx_valid, busy=0. rst asserted at byte 8 of a DATA frame -> all outputs 0 next cycle; next descriptor starts a fresh frame at byte 0.
- With MPU_FRAME_PAD_EN defined: ERR_DIM frame -> 60 bytes, bytes 15-59 = 00, tx_last on byte 59. A 5x5 DATA frame (90 bytes) -> unchanged, no padding.
